// File: rtl/design_slot_sequencer_if.sv
// Bundle of handshake, pad and per-design signals around the slot sequencer.
// The slave modport is the sequencer; master is everything around it.
interface design_slot_sequencer_if #(
    parameter int unsigned NUM_DESIGNS = 16,
    parameter int unsigned SEL_W       = 4,
    parameter int unsigned IO_W        = 12
);
    logic                        cfg_valid;
    logic [SEL_W-1:0]            cfg_sel;
    logic                        cfg_ready;
    logic                        cfg_err;
    logic [SEL_W-1:0]            active_sel;
    logic                        busy;
    logic [IO_W-1:0]             io_in;
    logic [IO_W-1:0]             io_out;
    logic [IO_W-1:0]             io_oeb;
    logic [NUM_DESIGNS*IO_W-1:0] des_io_out;
    logic [NUM_DESIGNS*IO_W-1:0] des_io_oeb;
    logic [IO_W-1:0]             des_io_in;
    logic [NUM_DESIGNS-1:0]      des_rst_n;

    modport master (
        output cfg_valid, cfg_sel, io_in, des_io_out, des_io_oeb,
        input  cfg_ready, cfg_err, active_sel, busy, io_out, io_oeb, des_io_in, des_rst_n
    );

    modport slave (
        input  cfg_valid, cfg_sel, io_in, des_io_out, des_io_oeb,
        output cfg_ready, cfg_err, active_sel, busy, io_out, io_oeb, des_io_in, des_rst_n
    );
endinterface

// File: rtl/design_slot_sequencer.sv
// Shares one bank of user I/O pins among several hosted designs, quiescing the pins
// and pulsing the incoming design's reset on every handover.
module design_slot_sequencer #(
    parameter int unsigned NUM_DESIGNS  = 16,
    parameter int unsigned SEL_W        = 4,
    parameter int unsigned IO_W         = 12,
    parameter int unsigned QUIET_CYCLES = 2,
    parameter int unsigned RST_CYCLES   = 8
) (
    input  logic                     clock,
    input  logic                     resetb,
    design_slot_sequencer_if.slave   bus
);

    localparam int unsigned CntMax = (QUIET_CYCLES > RST_CYCLES) ? QUIET_CYCLES : RST_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [1:0] StQuiet = 2'd0;
    localparam logic [1:0] StReset = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

    localparam logic [SEL_W:0] NumDes = (SEL_W + 1)'(NUM_DESIGNS);

    logic [1:0]             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]       active_q, active_d;
    logic [SEL_W-1:0]       target_q, target_d;
    logic                   err_q, err_d;
    logic [IO_W-1:0]        io_out_q, io_out_d;
    logic [IO_W-1:0]        io_oeb_q, io_oeb_d;
    logic [NUM_DESIGNS-1:0] rst_n_q, rst_n_d;

    logic                   run;
    logic [IO_W-1:0]        sel_out, sel_oeb;
    logic [NUM_DESIGNS-1:0] onehot_d;

    assign run = (state_q == StRun);

    always_comb begin
        sel_out = '0;
        sel_oeb = '1;
        for (int k = 0; k < int'(NUM_DESIGNS); k++) begin
            if (active_q == SEL_W'(k)) begin
                sel_out = bus.des_io_out[k*IO_W +: IO_W];
                sel_oeb = bus.des_io_oeb[k*IO_W +: IO_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        target_d = target_q;
        err_d    = err_q;
        case (state_q)
            StRun: begin
                if (bus.cfg_valid) begin
                    if ({1'b0, bus.cfg_sel} < NumDes) begin
                        err_d    = 1'b0;
                        target_d = bus.cfg_sel;
                        state_d  = StQuiet;
                        cnt_d    = CntW'(QUIET_CYCLES - 1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StQuiet: begin
                if (cnt_q == '0) begin
                    state_d  = StReset;
                    cnt_d    = CntW'(RST_CYCLES - 1);
                    active_d = target_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StReset: begin
                if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StReset;
                cnt_d   = CntW'(RST_CYCLES - 1);
            end
        endcase
    end

    // Design resets are registered from next-state so they never glitch.
    always_comb begin
        for (int k = 0; k < int'(NUM_DESIGNS); k++) begin
            onehot_d[k] = (active_d == SEL_W'(k));
        end
        rst_n_d  = (state_d == StReset) ? '0 : onehot_d;
        io_out_d = run ? sel_out : '0;
        io_oeb_d = run ? sel_oeb : '1;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= StReset;
            cnt_q    <= CntW'(RST_CYCLES - 1);
            active_q <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
            io_out_q <= '0;
            io_oeb_q <= '1;
            rst_n_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            target_q <= target_d;
            err_q    <= err_d;
            io_out_q <= io_out_d;
            io_oeb_q <= io_oeb_d;
            rst_n_q  <= rst_n_d;
        end
    end

    assign bus.cfg_ready  = run;
    assign bus.busy       = !run;
    assign bus.cfg_err    = err_q;
    assign bus.active_sel = active_q;
    assign bus.io_out     = io_out_q;
    assign bus.io_oeb     = io_oeb_q;
    assign bus.des_rst_n  = rst_n_q;
    assign bus.des_io_in  = run ? bus.io_in : '0;

endmodule

// File: tb/tb_design_slot_sequencer.sv
// Randomized and directed bench for design_slot_sequencer; the reference model tracks
// the handover as a countdown of cycles remaining until the pins are usable again.
module tb_design_slot_sequencer;

    localparam int unsigned ND = 12;
    localparam int unsigned SW = 4;
    localparam int unsigned IW = 12;
    localparam int unsigned QC = 2;
    localparam int unsigned RC = 8;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    design_slot_sequencer_if #(.NUM_DESIGNS(ND), .SEL_W(SW), .IO_W(IW)) bus ();

    design_slot_sequencer #(
        .NUM_DESIGNS (ND),
        .SEL_W       (SW),
        .IO_W        (IW),
        .QUIET_CYCLES(QC),
        .RST_CYCLES  (RC)
    ) dut (
        .clock (clock),
        .resetb(resetb),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: left = cycles until the pins are routed again (0 = running).
    int          left;
    int          cur;
    int          tgt;
    logic        m_err;
    logic [IW-1:0] m_out;
    logic [IW-1:0] m_oeb;
    bit          acc;
    int          c;
    int          g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        left  = RC;
        cur   = 0;
        tgt   = 0;
        m_err = 1'b0;
        m_out = '0;
        m_oeb = '1;
    endtask

    task automatic model_edge();
        acc = 1'b0;
        if (!resetb) begin
            model_reset();
        end else begin
            m_out = (left == 0) ? bus.des_io_out[cur*IW +: IW] : '0;
            m_oeb = (left == 0) ? bus.des_io_oeb[cur*IW +: IW] : '1;
            if (left == 0) begin
                if (bus.cfg_valid) begin
                    if (int'(bus.cfg_sel) < int'(ND)) begin
                        m_err = 1'b0;
                        tgt   = int'(bus.cfg_sel);
                        left  = QC + RC;
                        acc   = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else begin
                left--;
                if (left == int'(RC)) cur = tgt;
            end
        end
    endtask

    task automatic check_all();
        logic [ND-1:0] er;
        logic [IW-1:0] ein;
        er = '0;
        if (left == 0 || left > int'(RC)) er[cur] = 1'b1;
        ein = (left == 0) ? bus.io_in : '0;
        check("io_out",    64'(bus.io_out),     64'(m_out));
        check("io_oeb",    64'(bus.io_oeb),     64'(m_oeb));
        check("des_rst_n", 64'(bus.des_rst_n),  64'(er));
        check("active",    64'(bus.active_sel), 64'(cur));
        check("ready",     64'(bus.cfg_ready),  64'(left == 0));
        check("busy",      64'(bus.busy),       64'(left != 0));
        check("err",       64'(bus.cfg_err),    64'(m_err));
        check("des_io_in", 64'(bus.des_io_in),  64'(ein));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic request(input int sel);
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = SW'(sel);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!bus.cfg_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check("ready_bound", 64'(cyc < 40), 64'(1));
    endtask

    task automatic rand_data();
        for (int k = 0; k < int'(ND); k++) begin
            bus.des_io_out[k*IW +: IW] = IW'($urandom);
            bus.des_io_oeb[k*IW +: IW] = IW'($urandom);
        end
        bus.io_in = IW'($urandom);
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_sel    = '0;
        bus.io_in      = 12'h5C3;
        bus.des_io_out = '0;
        bus.des_io_oeb = '1;
        bus.des_io_out[0 +: IW] = 12'h3C3;
        bus.des_io_oeb[0 +: IW] = 12'h0F0;
        model_reset();

        // Power-on reset and first run of design 0.
        repeat (5) tick();
        check("por_oeb", 64'(bus.io_oeb), 64'(12'hFFF));
        resetb = 1'b1;
        repeat (7) tick();
        check("por_rst_pre", 64'(bus.des_rst_n), 64'(0));
        tick();
        check("por_rst_run", 64'(bus.des_rst_n), 64'(12'h001));
        tick();
        check("por_route", 64'(bus.io_out), 64'(12'h3C3));

        // Switch to design 5.
        bus.des_io_out[5*IW +: IW] = 12'hA5A;
        bus.des_io_oeb[5*IW +: IW] = 12'h000;
        request(5);
        wait_ready(c);
        check("sw5_low_cycles", 64'(c), 64'(10));
        tick();
        check("sw5_rst", 64'(bus.des_rst_n), 64'(12'h020));
        check("sw5_active", 64'(bus.active_sel), 64'(5));
        check("sw5_out", 64'(bus.io_out), 64'(12'hA5A));
        check("sw5_oeb", 64'(bus.io_oeb), 64'(12'h000));

        // Out-of-range index, then a valid one.
        request(13);
        check("inv_err", 64'(bus.cfg_err), 64'(1));
        check("inv_busy", 64'(bus.busy), 64'(0));
        check("inv_active", 64'(bus.active_sel), 64'(5));
        check("inv_out", 64'(bus.io_out), 64'(12'hA5A));
        request(2);
        check("inv_clear", 64'(bus.cfg_err), 64'(0));
        wait_ready(c);

        // Same-index handover re-resets design 3.
        request(3);
        wait_ready(c);
        request(3);
        c = 0;
        g = 0;
        while (!bus.cfg_ready && g < 40) begin
            tick();
            g++;
            if (!bus.des_rst_n[3]) c++;
        end
        check("same_total", 64'(g), 64'(10));
        check("same_rst_low", 64'(c), 64'(8));

        // Request held during a handover is taken once ready returns.
        request(1);
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = SW'(7);
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 40) begin
            tick();
            g++;
        end
        bus.cfg_valid = 1'b0;
        check("hold_taken", 64'(g), 64'(11));
        check("hold_busy", 64'(bus.busy), 64'(1));
        wait_ready(c);
        check("hold_active", 64'(bus.active_sel), 64'(7));

        // Asynchronous reset in the middle of a handover to design 9.
        request(9);
        repeat (4) tick();
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_oeb", 64'(bus.io_oeb), 64'(12'hFFF));
        check("arst_rst", 64'(bus.des_rst_n), 64'(0));
        check("arst_active", 64'(bus.active_sel), 64'(0));
        repeat (2) tick();
        resetb = 1'b1;
        wait_ready(c);
        check("arst_recover", 64'(c), 64'(8));
        check("arst_des0", 64'(bus.des_rst_n), 64'(12'h001));

        // Random traffic with occasional requests, valid and invalid.
        repeat (2000) begin
            rand_data();
            bus.cfg_valid = ($urandom_range(0, 7) == 0);
            bus.cfg_sel   = SW'($urandom_range(0, 15));
            tick();
        end
        bus.cfg_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/design_slot_sequencer.md
# design_slot_sequencer

Sequencer that shares one bank of user-project I/O pins among `NUM_DESIGNS` independent hosted designs. It accepts a design-select request from the management side and safely hands the pins over. The handover quiesces the pins, holds the outgoing design in reset and pulses reset on the incoming design. Only then does it route the selected design's outputs and output enables to `mprj_io`. It sits between the user-project wrapper pins and the per-design instances.

## Interface
Parameters:
- `NUM_DESIGNS`, 16, number of hosted designs (2..16).
- `SEL_W`, 4, select width; `2**SEL_W >= NUM_DESIGNS`.
- `IO_W`, 12, number of shared I/O pins.
- `QUIET_CYCLES`, 2, cycles pins are tristated before the new design enters reset (>=1).
- `RST_CYCLES`, 8, cycles the incoming design is held in reset (>=1).

Ports:
- `clock`  in  1  sole clock.
- `resetb`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  select request valid.
- `cfg_sel`  in  SEL_W  requested design index.
- `cfg_ready`  out  1  sequencer can accept a request.
- `cfg_err`  out  1  sticky: last request had an out-of-range index.
- `active_sel`  out  SEL_W  design currently owning or acquiring the pins.
- `busy`  out  1  handover in progress (QUIET or RESET state).
- `io_in`  in  IO_W  pad input values.
- `io_out`  out  IO_W  pad output values (registered).
- `io_oeb`  out  IO_W  pad output enables, active-low (registered).
- `des_io_out`  in  NUM_DESIGNS*IO_W  per-design outputs; design k occupies `[k*IO_W +: IO_W]`.
- `des_io_oeb`  in  NUM_DESIGNS*IO_W  per-design output enables, same packing.
- `des_io_in`  out  IO_W  pad inputs forwarded to the designs; zero unless in RUN.
- `des_rst_n`  out  NUM_DESIGNS  per-design active-low reset.

## Operation
FSM states are QUIET, RESET and RUN. The state counter is sized for max(QUIET_CYCLES, RST_CYCLES).

- **Reset values:** state=RESET, count=RST_CYCLES-1, active_sel=0, cfg_ready=0, cfg_err=0, busy=1, io_out=0, io_oeb=all 1, des_rst_n=all 0.
- **RUN:**
  - cfg_ready=1; des_rst_n[active_sel]=1, all other bits 0.
  - io_out and io_oeb register the active_sel slices of des_io_out and des_io_oeb.
  - des_io_in=io_in, combinational.
- **Request in RUN:** a request is accepted on an edge where cfg_valid && cfg_ready.
  - cfg_sel < NUM_DESIGNS: cfg_err clears, active_sel stays unchanged for now, state becomes QUIET, count=QUIET_CYCLES-1.
  - cfg_sel >= NUM_DESIGNS: cfg_err sets to 1; state, active_sel and the pins are unchanged.
  - cfg_sel == active_sel is valid; it performs a full handover, which re-resets that design.
- **QUIET:**
  - io_oeb=all 1, io_out=0, des_io_in=0.
  - The old design keeps its reset deasserted, so it can observe the released pins.
  - At count==0, all of des_rst_n go to 0, active_sel loads the captured index, state becomes RESET, count=RST_CYCLES-1.
- **RESET:**
  - Pins stay tristated, io_out=0; all of des_rst_n are 0.
  - At count==0, state becomes RUN.
- **Every non-RUN state:** cfg_ready=0 and busy=1. cfg_valid is ignored and the request is neither queued nor errored.
- **Mid-operation resetb assertion:** all outputs return to their reset values immediately (asynchronously). After release, the sequencer runs the RESET sequence for design 0.

## Timing
- **Handover from the acceptance edge E** (defaults):
  - State is QUIET for cycles E+1 to E+2 and RESET for E+3 to E+10.
  - RUN is entered at edge E+10, where cfg_ready rises and des_rst_n[new] rises.
  - The first routed io_out/io_oeb value appears at edge E+11, one register stage after RUN.
- **General case:** total unavailability is QUIET_CYCLES+RST_CYCLES cycles, plus 1 cycle of output-register latency.
- **After resetb release:** RUN is entered after RST_CYCLES edges and io_out is routed one edge later.
- **Rejected requests:** cfg_err updates at the acceptance edge; cfg_ready stays 1.
- **RUN latency:**
  - des_io_out to io_out is 1 cycle.
  - io_in to des_io_in is 0 cycles (combinational).
- **Handshake:** back-to-back requests are impossible, since cfg_ready is low for the whole handover.

## Test plan
- **Reset:** resetb low for 5 cycles, then release. Required: io_oeb=0xFFF and des_rst_n=0x0000 until RUN; des_rst_n=0x0001 at release edge +8; io_out equals des 0's slice one edge later.
- **Switch to design 5:** cfg_sel=5, with des 5 driving 0xA5A and oeb 0x000. Required: cfg_ready low for exactly 10 cycles; des_rst_n=0x0000 during RESET; then des_rst_n=0x0020, active_sel=5, io_out=0xA5A, io_oeb=0x000.
- **Invalid index:** NUM_DESIGNS=12, cfg_sel=13 in RUN. Required: cfg_err=1; busy stays 0; active_sel and io_out unchanged. A following valid cfg_sel=2 clears cfg_err at its acceptance edge.
- **Same-index handover:** cfg_sel == active_sel=3. Required: the full 10-cycle sequence runs and des_rst_n[3] pulses low for 8 cycles.
- **Request during handover:** cfg_valid held with cfg_sel=7 while busy. Required: no effect until cfg_ready rises; it is then accepted and starts a second handover.
- **Async reset mid-RESET:** resetb pulsed low during RESET toward design 9. Required: outputs return to reset values immediately; the sequencer recovers to design 0 in RUN after 8 cycles.
